// File: rtl/signed_display_driver.sv
// Two's-complement result to sign-magnitude BCD, shown on a 4-digit multiplexed
// common-anode 7-segment display. Sequential double-dabble runs for 8 cycles.
module signed_display_driver #(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       ovfl,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;
  localparam logic [6:0] SegE     = 7'b0000110;

  typedef enum logic [1:0] {StIdle, StAbs, StShift, StDone} state_e;

  state_e                  state_q;
  logic [7:0]              value_q;
  logic                    ovfl_q;
  logic                    neg_q;
  logic [19:0]             dd_q;
  logic [2:0]              cnt_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic                    valid_q;
  logic                    disp_neg_q;
  logic                    disp_ovfl_q;
  logic [3:0]              disp_h_q;
  logic [3:0]              disp_t_q;
  logic [3:0]              disp_o_q;
  logic                    busy_q;
  logic [6:0]              seg_q;
  logic [3:0]              an_q;

  logic [7:0]  mag;
  logic [19:0] dd_adj;
  logic        nxt_valid;
  logic        nxt_neg;
  logic        nxt_ovfl;
  logic [3:0]  nxt_h;
  logic [3:0]  nxt_t;
  logic [3:0]  nxt_o;
  logic [6:0]  dig [4];
  logic [1:0]  sel;
  logic [6:0]  seg_d;
  logic [3:0]  an_d;

  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  always_comb begin
    mag    = value_q[7] ? (~value_q + 8'd1) : value_q;
    dd_adj = dd_q;
    if (dd_q[11:8]  >= 4'd5) dd_adj[11:8]  = dd_q[11:8]  + 4'd3;
    if (dd_q[15:12] >= 4'd5) dd_adj[15:12] = dd_q[15:12] + 4'd3;
    if (dd_q[19:16] >= 4'd5) dd_adj[19:16] = dd_q[19:16] + 4'd3;
  end

  // The scan register looks at the display contents being written this edge,
  // so new digits reach seg/an on the same edge that ends DONE.
  always_comb begin
    nxt_valid = valid_q;
    nxt_neg   = disp_neg_q;
    nxt_ovfl  = disp_ovfl_q;
    nxt_h     = disp_h_q;
    nxt_t     = disp_t_q;
    nxt_o     = disp_o_q;
    if (state_q == StDone) begin
      nxt_valid = 1'b1;
      nxt_neg   = neg_q;
      nxt_ovfl  = ovfl_q;
      nxt_h     = dd_q[19:16];
      nxt_t     = dd_q[15:12];
      nxt_o     = dd_q[11:8];
    end
    dig[0] = SegBlank;
    dig[1] = SegBlank;
    dig[2] = SegBlank;
    dig[3] = SegE;
    if (!nxt_ovfl) begin
      dig[3] = nxt_neg ? SegMinus : SegBlank;
      dig[2] = (nxt_h == 4'd0) ? SegBlank : enc_digit(nxt_h);
      dig[1] = (nxt_h == 4'd0 && nxt_t == 4'd0) ? SegBlank : enc_digit(nxt_t);
      dig[0] = enc_digit(nxt_o);
    end
    sel   = refresh_q[REFRESH_BITS-1 -: 2];
    seg_d = SegBlank;
    an_d  = 4'b1111;
    if (nxt_valid) begin
      seg_d = dig[sel];
      an_d  = ~(4'b0001 << sel);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      value_q     <= 8'd0;
      ovfl_q      <= 1'b0;
      neg_q       <= 1'b0;
      dd_q        <= 20'd0;
      cnt_q       <= 3'd0;
      refresh_q   <= '0;
      valid_q     <= 1'b0;
      disp_neg_q  <= 1'b0;
      disp_ovfl_q <= 1'b0;
      disp_h_q    <= 4'd0;
      disp_t_q    <= 4'd0;
      disp_o_q    <= 4'd0;
      busy_q      <= 1'b0;
      seg_q       <= SegBlank;
      an_q        <= 4'b1111;
    end else begin
      refresh_q   <= refresh_q + REFRESH_BITS'(1);
      seg_q       <= seg_d;
      an_q        <= an_d;
      valid_q     <= nxt_valid;
      disp_neg_q  <= nxt_neg;
      disp_ovfl_q <= nxt_ovfl;
      disp_h_q    <= nxt_h;
      disp_t_q    <= nxt_t;
      disp_o_q    <= nxt_o;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            value_q <= value;
            ovfl_q  <= ovfl;
            busy_q  <= 1'b1;
            state_q <= StAbs;
          end
        end
        StAbs: begin
          neg_q   <= value_q[7];
          dd_q    <= {12'd0, mag};
          cnt_q   <= 3'd0;
          state_q <= StShift;
        end
        StShift: begin
          dd_q  <= {dd_adj[18:0], 1'b0};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_signed_display_driver.sv
// Randomised and directed bench for signed_display_driver; expected digits come
// from plain integer arithmetic on the signed input value.
module tb_signed_display_driver;

  localparam logic [6:0] Blank = 7'b1111111;
  localparam logic [6:0] Minus = 7'b0111111;
  localparam logic [6:0] LetE  = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic       ovfl = 1'b0;
  logic       load = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] scan_seg [16];
  logic [3:0] scan_an  [16];

  signed_display_driver #(.REFRESH_BITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .value(value),
    .ovfl (ovfl),
    .load (load),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] enc(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  // Expected glyph per digit position (index 0 = rightmost).
  function automatic logic [3:0][6:0] model(input logic [7:0] v, input logic o);
    logic [3:0][6:0] r;
    int s, mag, h, t, u;
    s   = int'($signed(v));
    mag = (s < 0) ? -s : s;
    h   = mag / 100;
    t   = (mag / 10) % 10;
    u   = mag % 10;
    r   = {Blank, Blank, Blank, Blank};
    if (o) begin
      r[3] = LetE;
    end else begin
      r[3] = (s < 0) ? Minus : Blank;
      if (h != 0) r[2] = enc(h);
      if (h != 0 || t != 0) r[1] = enc(t);
      r[0] = enc(u);
    end
    return r;
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Load one value and count how many sampled cycles busy stays high.
  task automatic do_conv(input logic [7:0] v, input logic o, output int blen);
    value = v;
    ovfl  = o;
    load  = 1'b1;
    step();
    load = 1'b0;
    blen = 0;
    while (busy === 1'b1 && blen < 30) begin
      blen++;
      step();
    end
  endtask

  task automatic scan();
    for (int k = 0; k < 16; k++) begin
      scan_seg[k] = seg;
      scan_an[k]  = an;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== Blank) begin
      n_err++;
      $display("FAIL reset_state: busy=%b an=%b seg=%b, need 0 1111 1111111", busy, an, seg);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || an !== 4'b1111 || seg !== Blank) begin
        n_err++;
        $display("FAIL idle_blank: busy=%b an=%b seg=%b, need 0 1111 1111111", busy, an, seg);
      end
    end
  endtask

  task automatic test_convert(input logic [7:0] v, input logic o);
    int blen, idx, prev;
    logic [3:0][6:0] exp;
    logic [3:0] seen;
    exp = model(v, o);
    do_conv(v, o, blen);
    n_cmp++;
    if (blen != 10) begin
      n_err++;
      $display("FAIL busy_len v=%h o=%b: got %0d cycles, need 10", v, o, blen);
    end
    scan();
    seen = 4'b0;
    prev = -1;
    for (int k = 0; k < 16; k++) begin
      idx = an_idx(scan_an[k]);
      n_cmp++;
      if (idx < 0) begin
        n_err++;
        $display("FAIL an_onehot v=%h k=%0d: an=%b, need one low bit", v, k, scan_an[k]);
      end else begin
        seen[idx] = 1'b1;
        if (scan_seg[k] !== exp[idx]) begin
          n_err++;
          $display("FAIL digit v=%h o=%b pos=%0d: seg=%b, need %b",
                   v, o, idx, scan_seg[k], exp[idx]);
        end
        if (prev >= 0 && idx != prev && idx != (prev + 1) % 4) begin
          n_err++;
          $display("FAIL scan_order v=%h: digit %0d after %0d, need %0d", v, idx, prev,
                   (prev + 1) % 4);
        end
        prev = idx;
      end
    end
    n_cmp++;
    if (seen !== 4'b1111) begin
      n_err++;
      $display("FAIL scan_cover v=%h: seen=%b, need 1111", v, seen);
    end
  endtask

  task automatic test_directed();
    test_convert(8'h05, 1'b0);
    test_convert(8'hF6, 1'b0);
    test_convert(8'h80, 1'b0);
    test_convert(8'h7F, 1'b0);
    test_convert(8'h80, 1'b1);
    test_convert(8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      test_convert(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_busy_ignore();
    logic [3:0][6:0] old_exp, exp;
    int idx;
    test_convert(8'h05, 1'b0);
    old_exp = model(8'h05, 1'b0);
    exp     = model(8'h09, 1'b0);
    value = 8'h09;
    ovfl  = 1'b0;
    load  = 1'b1;
    step();
    load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      n_cmp++;
      idx = an_idx(an);
      if (busy !== 1'b1 || idx < 0 || seg !== old_exp[idx]) begin
        n_err++;
        $display("FAIL busy_hold cycle %0d: busy=%b an=%b seg=%b, need busy=1 old digits",
                 i, busy, an, seg);
      end
      // Stray loads land on a SHIFT edge and on the edge that ends DONE.
      if (i == 4 || i == 10) begin
        value = 8'h63;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      idx = an_idx(an);
      if (busy !== 1'b0 || idx < 0 || seg !== exp[idx]) begin
        n_err++;
        $display("FAIL ignore_load k=%0d: busy=%b an=%b seg=%b, need busy=0 showing 9",
                 k, busy, an, seg);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    value = 8'h55;
    ovfl  = 1'b0;
    load  = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || an !== 4'b1111 || seg !== Blank) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b an=%b seg=%b, need 0 1111 1111111", busy, an, seg);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || an !== 4'b1111 || seg !== Blank) begin
        n_err++;
        $display("FAIL reset_mid_after k=%0d: busy=%b an=%b seg=%b, need 0 1111 1111111",
                 k, busy, an, seg);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][6:0] exp;
    logic exp_busy;
    int idx;
    exp   = model(8'h2A, 1'b0);
    value = 8'h2A;
    ovfl  = 1'b0;
    load  = 1'b1;
    step();
    for (int k = 0; k < 40; k++) begin
      exp_busy = (k % 11) != 10;
      n_cmp++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL b2b_busy k=%0d: busy=%b, need %b", k, busy, exp_busy);
      end
      n_cmp++;
      if (k < 10) begin
        if (an !== 4'b1111 || seg !== Blank) begin
          n_err++;
          $display("FAIL b2b_blank k=%0d: an=%b seg=%b, need 1111 1111111", k, an, seg);
        end
      end else begin
        idx = an_idx(an);
        if (idx < 0 || seg !== exp[idx]) begin
          n_err++;
          $display("FAIL b2b_digit k=%0d: an=%b seg=%b, need digits of 42", k, an, seg);
        end
      end
      step();
    end
    load = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
